// File: rtl/ram_pkg.sv
// Shared definitions for the sized-access data RAM: access sizes, FSM states
// and the alignment rule used by both the controller and the lane aligner.
package ram_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // size 2'b11 is reserved and therefore never aligned
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b1;
            SIZE_HALF: return ~addr_lo[0];
            SIZE_WORD: return (addr_lo == 2'b00);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_lane_align.sv
// Big-endian lane steering: byte offset k within a word lives in bits [31-8k -: 8].
// Produces byte enables and lane-placed write data, and right-justifies read data.
module ram_lane_align
    import ram_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlane,
    output logic [31:0] rdata
);

    // be[k] enables byte offset k; misaligned accesses leave everything zero
    always_comb begin
        be    = 4'b0000;
        wlane = 32'h0;
        rdata = 32'h0;
        if (is_aligned(size, addr_lo)) begin
            case (size)
                SIZE_BYTE: begin
                    be    = 4'b0001 << addr_lo;
                    wlane = {4{wdata[7:0]}};
                    case (addr_lo)
                        2'd0:    rdata = {24'h0, rword[31:24]};
                        2'd1:    rdata = {24'h0, rword[23:16]};
                        2'd2:    rdata = {24'h0, rword[15:8]};
                        default: rdata = {24'h0, rword[7:0]};
                    endcase
                end
                SIZE_HALF: begin
                    be    = addr_lo[1] ? 4'b1100 : 4'b0011;
                    wlane = {2{wdata[15:0]}};
                    rdata = {16'h0, (addr_lo[1] ? rword[15:0] : rword[31:16])};
                end
                default: begin
                    be    = 4'b1111;
                    wlane = wdata;
                    rdata = rword;
                end
            endcase
        end
    end

endmodule

// File: rtl/ram_sized_access.sv
// Byte-addressable data RAM with MOV/MOC handshake, byte/half/word accesses,
// big-endian lanes, alignment checking and a programmable wait-state count.
//
//  state  | meaning
//  S_IDLE | waiting for mov; request fields latched on the accepting edge
//  S_WAIT | down-counting wait states; commit on the edge leaving with cnt=0
//  S_DONE | moc high (align_err qualifies it); leave when mov is sampled low
module ram_sized_access
    import ram_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mov,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              moc,
    output logic              align_err
);

    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    logic [7:0] mem [0:DEPTH-1];

    state_t            state, state_nx;
    logic [3:0]        cnt, cnt_nx;
    logic              accept, commit;
    logic              rw_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [3:0]        be;
    logic [31:0]       wlane, rword, rdata;
    logic [ADDR_W-3:0] word_idx;

    assign word_idx = addr_q[ADDR_W-1:2];
    assign rword    = {mem[{word_idx, 2'd0}], mem[{word_idx, 2'd1}],
                       mem[{word_idx, 2'd2}], mem[{word_idx, 2'd3}]};

    ram_lane_align u_lane (
        .size    (size_q),
        .addr_lo (addr_q[1:0]),
        .wdata   (wdata_q),
        .rword   (rword),
        .be      (be),
        .wlane   (wlane),
        .rdata   (rdata)
    );

    // WAIT always spends LATENCY+1 edges, so DONE lands LATENCY+1 edges after accept
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        commit   = 1'b0;
        case (state)
            S_IDLE: begin
                if (mov) begin
                    accept   = 1'b1;
                    cnt_nx   = LAT_INIT;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    commit   = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            S_DONE: begin
                if (!mov) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            rw_q     <= 1'b0;
            size_q   <= SIZE_BYTE;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            data_out <= 32'h0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                rw_q    <= rw;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= data_in;
                err_q   <= ~is_aligned(size, addr[1:0]);
            end
            if (commit) begin
                if (err_q)
                    data_out <= 32'h0;
                else if (rw_q)
                    data_out <= rdata;
            end
        end
    end

    // array has no reset; commit is only reachable from WAIT, so reset kills pending writes
    always_ff @(posedge clk) begin
        if (commit && !rw_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[{word_idx, 2'(i)}] <= wlane[31-8*i -: 8];
            end
        end
    end

    assign moc       = (state == S_DONE);
    assign align_err = moc & err_q;

endmodule
